mmix_mem_arbiter: RTL and testbench

MMIX_MEM_ARBITER -- requirements
Module: mmix_mem_arbiter

---
 rtl/mmix_bus_pkg.sv | 32 +++
 rtl/mmix_arb_pick.sv | 37 +++
 rtl/mmix_mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mmix_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmix_bus_pkg.sv
// Shared MMIX memory-bus definitions: transfer-size encoding, arbiter
// state encoding, port count and small request helpers.
package mmix_bus_pkg;

    localparam int MMIX_ARB_PORTS = 2;

    // Downstream transfer size
    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        WYDE  = 2'd1,
        TETRA = 2'd2,
        OCTA  = 2'd3
    } mmix_datasize_e;

    // Arbiter sequencing: one transaction at a time, DONE forces a gap
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } mmix_arb_state_e;

    // True when any requester is asking for the bus
    function automatic logic arb_any_request(input logic [MMIX_ARB_PORTS-1:0] req);
        return |req;
    endfunction

    // A requester raising read and write together is served as a read
    function automatic logic arb_eff_write(input logic rd, input logic wr);
        return wr & ~rd;
    endfunction

endpackage

// File: rtl/mmix_arb_pick.sv
// Grant selection for the two-port MMIX memory arbiter.
// MMIX_ARB_ROUND_ROBIN_EN selects alternating priority on collisions;
// otherwise port 1 (data) always wins. With no request pending the
// winner simply echoes last_grant.
module mmix_arb_pick
    import mmix_bus_pkg::*;
(
    input  logic [MMIX_ARB_PORTS-1:0] requests,
    input  logic                      last_grant,
    output logic                      winner
);

    // Choose which port receives the next grant
    always_comb begin
        winner = last_grant;
`ifdef MMIX_ARB_ROUND_ROBIN_EN
        if (requests[1] && requests[0]) begin
            winner = ~last_grant;
        end else if (requests[1]) begin
            winner = 1'b1;
        end else if (requests[0]) begin
            winner = 1'b0;
        end else begin
            winner = last_grant;
        end
`else
        if (requests[1]) begin
            winner = 1'b1;
        end else if (requests[0]) begin
            winner = 1'b0;
        end else begin
            winner = last_grant;
        end
`endif
    end

endmodule

// File: rtl/mmix_mem_arbiter.sv
// Two-port MMIX memory arbiter (port 0 instruction fetch, port 1 data)
// in front of a single downstream memory port. One transaction at a time:
// IDLE arbitrates, BUSY drives the downstream request from registers until
// mmix_done, DONE pulses the granted sN_done and returns to IDLE.
// Build option: MMIX_ARB_ROUND_ROBIN_EN enables round-robin collision
// resolution; the default build uses fixed priority with port 1 winning.
module mmix_mem_arbiter
    import mmix_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [63:0] s0_address,
    input  logic [1:0]  s0_datasize,
    input  logic [63:0] s0_writedata,
    output logic [63:0] s0_readdata,
    output logic        s0_done,

    input  logic        s1_read,
    input  logic        s1_write,
    input  logic [63:0] s1_address,
    input  logic [1:0]  s1_datasize,
    input  logic [63:0] s1_writedata,
    output logic [63:0] s1_readdata,
    output logic        s1_done,

    output logic [63:0] mmix_address,
    output logic [1:0]  mmix_datasize,
    output logic        mmix_read,
    input  logic [63:0] mmix_readdata,
    output logic        mmix_write,
    output logic [63:0] mmix_writedata,
    input  logic        mmix_done
);

    localparam logic [1:0] ST_IDLE = ARB_IDLE;
    localparam logic [1:0] ST_BUSY = ARB_BUSY;
    localparam logic [1:0] ST_DONE = ARB_DONE;

    logic [1:0]                state_r;
    logic [1:0]                state_nx_s;
    logic                      grant_r;
    logic                      last_grant_r;
    logic [MMIX_ARB_PORTS-1:0] req_s;
    logic                      winner_s;
    logic                      arb_fire_s;
    logic                      finish_s;

    logic                      sel_read_s;
    logic                      sel_write_s;
    logic [63:0]               sel_address_s;
    logic [1:0]                sel_datasize_s;
    logic [63:0]               sel_writedata_s;

    logic [63:0]               mmix_address_r;
    mmix_datasize_e            mmix_datasize_r;
    logic                      mmix_read_r;
    logic                      mmix_write_r;
    logic [63:0]               mmix_writedata_r;
    logic [63:0]               s0_readdata_r;
    logic [63:0]               s1_readdata_r;
    logic                      s0_done_r;
    logic                      s1_done_r;

    mmix_arb_pick u_pick (
        .requests   (req_s),
        .last_grant (last_grant_r),
        .winner     (winner_s)
    );

    // Collect pending requests and qualify arbitration / completion events
    always_comb begin
        req_s      = '0;
        req_s[0]   = s0_read | s0_write;
        req_s[1]   = s1_read | s1_write;
        arb_fire_s = (state_r == ST_IDLE) && arb_any_request(req_s);
        finish_s   = (state_r == ST_BUSY) && mmix_done;
    end

    // Route the winning requester's command fields toward the latch
    always_comb begin
        sel_read_s      = 1'b0;
        sel_write_s     = 1'b0;
        sel_address_s   = 64'd0;
        sel_datasize_s  = 2'd0;
        sel_writedata_s = 64'd0;
        if (winner_s) begin
            sel_read_s      = s1_read;
            sel_write_s     = arb_eff_write(s1_read, s1_write);
            sel_address_s   = s1_address;
            sel_datasize_s  = s1_datasize;
            sel_writedata_s = s1_writedata;
        end else begin
            sel_read_s      = s0_read;
            sel_write_s     = arb_eff_write(s0_read, s0_write);
            sel_address_s   = s0_address;
            sel_datasize_s  = s0_datasize;
            sel_writedata_s = s0_writedata;
        end
    end

    // Next-state logic; DONE always returns to IDLE without arbitrating
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_fire_s) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (finish_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant bookkeeping; last_grant starts at 1 so port 0 wins the first collision under round-robin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (arb_fire_s) begin
            grant_r      <= winner_s;
            last_grant_r <= winner_s;
        end else begin
            grant_r      <= grant_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Downstream command registers: loaded at arbitration, strobes dropped on mmix_done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmix_address_r   <= 64'd0;
            mmix_datasize_r  <= BYTE;
            mmix_writedata_r <= 64'd0;
            mmix_read_r      <= 1'b0;
            mmix_write_r     <= 1'b0;
        end else if (arb_fire_s) begin
            mmix_address_r   <= sel_address_s;
            mmix_datasize_r  <= mmix_datasize_e'(sel_datasize_s);
            mmix_writedata_r <= sel_writedata_s;
            mmix_read_r      <= sel_read_s;
            mmix_write_r     <= sel_write_s;
        end else if (finish_s) begin
            mmix_read_r      <= 1'b0;
            mmix_write_r     <= 1'b0;
        end else begin
            mmix_read_r      <= mmix_read_r;
            mmix_write_r     <= mmix_write_r;
        end
    end

    // Read data return: only a completed read updates the granted port's register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_readdata_r <= 64'd0;
            s1_readdata_r <= 64'd0;
        end else if (finish_s && mmix_read_r) begin
            if (grant_r) begin
                s1_readdata_r <= mmix_readdata;
            end else begin
                s0_readdata_r <= mmix_readdata;
            end
        end else begin
            s0_readdata_r <= s0_readdata_r;
            s1_readdata_r <= s1_readdata_r;
        end
    end

    // Completion pulse: high for exactly the DONE cycle on the granted port only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_done_r <= 1'b0;
            s1_done_r <= 1'b0;
        end else begin
            s0_done_r <= finish_s & ~grant_r;
            s1_done_r <= finish_s &  grant_r;
        end
    end

    assign mmix_address   = mmix_address_r;
    assign mmix_datasize  = mmix_datasize_r;
    assign mmix_read      = mmix_read_r;
    assign mmix_write     = mmix_write_r;
    assign mmix_writedata = mmix_writedata_r;
    assign s0_readdata    = s0_readdata_r;
    assign s1_readdata    = s1_readdata_r;
    assign s0_done        = s0_done_r;
    assign s1_done        = s1_done_r;

endmodule

// File: tb/tb_mmix_mem_arbiter.sv
// Scoreboard bench for mmix_mem_arbiter: requester tasks record requests,
// a downstream responder model answers with random latency, and a monitor
// predicts grants and completions from the arbitration rules.
module tb_mmix_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rq_rd = 2'b00;
    logic [1:0]  rq_wr = 2'b00;
    logic [63:0] rq_addr [2];
    logic [63:0] rq_wdata [2];
    logic [1:0]  rq_size [2];

    logic [63:0] s0_readdata, s1_readdata, mmix_address, mmix_writedata;
    logic [63:0] mmix_readdata = 64'd0;
    logic [1:0]  mmix_datasize;
    logic        s0_done, s1_done, mmix_read, mmix_write;
    logic        mmix_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state
    bit          pend [2];
    bit          served [2];
    int          issue_cyc [2];
    bit          m_rd [2];
    bit          m_wr [2];
    logic [63:0] m_addr [2];
    logic [63:0] m_wdata [2];
    logic [1:0]  m_size [2];
    logic [63:0] rd_model [2];
    bit          lg_m = 1'b1;
    int          grant_log [$];
    typedef struct { int port; logic [63:0] data; int cyc; } cmp_t;
    cmp_t        sbq [$];

    // monitor bookkeeping
    bit          prev_active = 1'b0;
    int          cur_w;
    logic [63:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_rd, cur_wr;
    int          busy_start, busy_len, last_start_cyc;

    // downstream responder knobs
    int          ds_cnt = 0, ds_lat = 1, ds_force_lat = 0;
    bit          ds_force_data_en = 1'b0;
    logic [63:0] ds_force_data = 64'd0;
    bit          spur_en = 1'b0;

    mmix_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_read(rq_rd[0]), .s0_write(rq_wr[0]), .s0_address(rq_addr[0]),
        .s0_datasize(rq_size[0]), .s0_writedata(rq_wdata[0]),
        .s0_readdata(s0_readdata), .s0_done(s0_done),
        .s1_read(rq_rd[1]), .s1_write(rq_wr[1]), .s1_address(rq_addr[1]),
        .s1_datasize(rq_size[1]), .s1_writedata(rq_wdata[1]),
        .s1_readdata(s1_readdata), .s1_done(s1_done),
        .mmix_address(mmix_address), .mmix_datasize(mmix_datasize),
        .mmix_read(mmix_read), .mmix_readdata(mmix_readdata),
        .mmix_write(mmix_write), .mmix_writedata(mmix_writedata),
        .mmix_done(mmix_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // policy as stated: collision -> other than last grant (round-robin) or port 1
    function automatic int pick_model(bit e0, bit e1, bit lg);
        if (e0 && e1) begin
`ifdef MMIX_ARB_ROUND_ROBIN_EN
            return lg ? 0 : 1;
`else
            return 1;
`endif
        end
        return e1 ? 1 : 0;
    endfunction

    // downstream memory: random latency 1..4 once a request is visible, spurious pulses when idle
    always @(posedge clk) begin
        #1;
        if (reset) begin
            ds_cnt = 0;
            mmix_done = 1'b0;
        end else if (mmix_read || mmix_write) begin
            if (ds_cnt == 0) ds_lat = (ds_force_lat != 0) ? ds_force_lat : int'($urandom_range(1, 4));
            ds_cnt++;
            mmix_done = (ds_cnt == ds_lat);
            mmix_readdata = (mmix_done && ds_force_data_en) ? ds_force_data : {$urandom, $urandom};
        end else begin
            ds_cnt = 0;
            mmix_done = spur_en && ($urandom_range(0, 5) == 0);
            mmix_readdata = {$urandom, $urandom};
        end
    end

    // monitor: predict each grant, check held fields, queue and check completions
    always @(negedge clk) begin
        if (!reset) begin
            bit e0, e1, act;
            int w, p;
            cmp_t e;
            act = mmix_read || mmix_write;
            if (mmix_read && mmix_write) chk("rd_wr_exclusive", 64'd1, 64'd0);
            if (s0_done && s1_done) chk("done_exclusive", 64'd1, 64'd0);
            if (act && !prev_active) begin
                e0 = pend[0] && !served[0] && (issue_cyc[0] < cyc);
                e1 = pend[1] && !served[1] && (issue_cyc[1] < cyc);
                if (!e0 && !e1) begin
                    chk("start_without_request", 64'd1, 64'd0);
                end else begin
                    w = pick_model(e0, e1, lg_m);
                    chk("grant_read", {63'd0, mmix_read}, {63'd0, m_rd[w]});
                    chk("grant_write", {63'd0, mmix_write}, {63'd0, m_wr[w]});
                    chk("grant_addr", mmix_address, m_addr[w]);
                    chk("grant_size", {62'd0, mmix_datasize}, {62'd0, m_size[w]});
                    chk("grant_wdata", mmix_writedata, m_wdata[w]);
                    served[w] = 1'b1;
                    lg_m = w[0];
                    grant_log.push_back(w);
                    cur_w = w; cur_addr = m_addr[w]; cur_wdata = m_wdata[w];
                    cur_size = m_size[w]; cur_rd = m_rd[w]; cur_wr = m_wr[w];
                    busy_start = cyc; last_start_cyc = cyc;
                end
            end else if (act) begin
                if (mmix_address !== cur_addr || mmix_writedata !== cur_wdata ||
                    mmix_datasize !== cur_size || mmix_read !== cur_rd || mmix_write !== cur_wr)
                    chk("busy_stable", {cur_rd, cur_wr, mmix_address[61:0]}, {cur_rd, cur_wr, cur_addr[61:0]});
            end
            if (act && mmix_done) begin
                e.port = cur_w;
                e.cyc  = cyc + 1;
                if (cur_rd) rd_model[cur_w] = mmix_readdata;
                e.data = rd_model[cur_w];
                sbq.push_back(e);
                busy_len = cyc - busy_start + 1;
            end
            if (s0_done || s1_done) begin
                p = s1_done ? 1 : 0;
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_port", 64'(p), 64'(e.port));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("readdata", p ? s1_readdata : s0_readdata, e.data);
                end
                pend[p] = 1'b0;
                served[p] = 1'b0;
            end
            prev_active = act;
        end
    end

    task automatic clear_model();
        pend[0] = 1'b0; pend[1] = 1'b0; served[0] = 1'b0; served[1] = 1'b0;
        rd_model[0] = 64'd0; rd_model[1] = 64'd0;
        lg_m = 1'b1; sbq.delete(); prev_active = 1'b0;
        rq_rd = 2'b00; rq_wr = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mmix_read"}, {63'd0, mmix_read}, 64'd0);
        chk({tag, "_mmix_write"}, {63'd0, mmix_write}, 64'd0);
        chk({tag, "_s0_done"}, {63'd0, s0_done}, 64'd0);
        chk({tag, "_s1_done"}, {63'd0, s1_done}, 64'd0);
        chk({tag, "_mmix_address"}, mmix_address, 64'd0);
        chk({tag, "_mmix_writedata"}, mmix_writedata, 64'd0);
        chk({tag, "_mmix_datasize"}, {62'd0, mmix_datasize}, 64'd0);
        chk({tag, "_s0_readdata"}, s0_readdata, 64'd0);
        chk({tag, "_s1_readdata"}, s1_readdata, 64'd0);
    endtask

    // reset asserted mid-cycle, outputs checked asynchronously, released away from the edge
    task automatic pulse_reset(input string tag);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        clear_model();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // call just after a rising edge; raises the request and records it in the model
    task automatic raise_req(input int p, input bit rd, input bit wr, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [1:0] size);
        rq_rd[p] = rd; rq_wr[p] = wr; rq_addr[p] = addr; rq_wdata[p] = wdata; rq_size[p] = size;
        m_rd[p] = rd; m_wr[p] = wr && !rd; m_addr[p] = addr; m_wdata[p] = wdata; m_size[p] = size;
        issue_cyc[p] = cyc; served[p] = 1'b0; pend[p] = 1'b1;
    endtask

    task automatic do_txn(input int p, input bit rd, input bit wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size,
                          input int gap, input bit withdraw);
        bit got;
        got = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        raise_req(p, rd, wr, addr, wdata, size);
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge clk);
            if ((p == 0) ? s0_done : s1_done) got = 1'b1;
            else if (withdraw && served[p] && $urandom_range(0, 2) == 0) begin
                rq_rd[p] = 1'b0; rq_wr[p] = 1'b0;
            end
        end
        if (!got) begin
            chk("done_timeout", 64'd0, 64'd1);
            pend[p] = 1'b0;
        end
        @(posedge clk); #1;
        rq_rd[p] = 1'b0; rq_wr[p] = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = $urandom_range(0, 3);
            do_txn(p, k != 1, (k == 1) || (k == 2), {$urandom, $urandom}, {$urandom, $urandom},
                   2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        int t0, gl_before;
        bit seen;
        rq_addr[0] = 64'd0; rq_addr[1] = 64'd0; rq_wdata[0] = 64'd0; rq_wdata[1] = 64'd0;
        rq_size[0] = 2'd0; rq_size[1] = 2'd0;
        pulse_reset("rst0");

        // s0 octa read of 0x58, downstream latency 2
        ds_force_lat = 2; ds_force_data_en = 1'b1; ds_force_data = 64'h0123456789ABCDEF;
        t0 = cyc;
        do_txn(0, 1'b1, 1'b0, 64'h58, 64'd0, 2'd3, 0, 1'b0);
        chk("t24_busy_cycles", 64'(busy_len), 64'd2);
        chk("t24_arb_edge", 64'(last_start_cyc), 64'(t0 + 1));
        chk("t24_s0_readdata", s0_readdata, 64'h0123456789ABCDEF);
        ds_force_lat = 0; ds_force_data_en = 1'b0;

        // s1 tetra write leaves s1_readdata alone
        do_txn(1, 1'b0, 1'b1, 64'h94, 64'hDEADBEEF, 2'd2, 0, 1'b0);
        chk("t26_last_write", {63'd0, cur_wr}, 64'd1);
        chk("t26_last_addr", cur_addr, 64'h94);
        chk("t26_s1_readdata", s1_readdata, 64'd0);

        // spurious mmix_done while idle, then read+write together
        spur_en = 1'b1;
        gl_before = grant_log.size();
        repeat (12) @(posedge clk);
        #1;
        chk("t29_no_spurious_start", 64'(grant_log.size()), 64'(gl_before));
        chk("t29_idle_lines", {62'd0, mmix_read, mmix_write}, 64'd0);
        do_txn(0, 1'b1, 1'b1, 64'h1000, 64'hCAFE, 2'd1, 0, 1'b0);
        chk("t29_as_read", {62'd0, cur_rd, cur_wr}, 64'd2);

        // simultaneous reads from reset
        pulse_reset("rst1");
        grant_log.delete();
        fork
            do_txn(0, 1'b1, 1'b0, 64'h200, 64'd0, 2'd3, 0, 1'b0);
            do_txn(1, 1'b1, 1'b0, 64'h300, 64'd0, 2'd3, 0, 1'b0);
        join
        chk("t25_grant_count", 64'(grant_log.size()), 64'd2);
`ifdef MMIX_ARB_ROUND_ROBIN_EN
        chk("t25_first_grant", 64'(grant_log[0]), 64'd0);
        chk("t25_second_grant", 64'(grant_log[1]), 64'd1);
`else
        chk("t25_first_grant", 64'(grant_log[0]), 64'd1);
        chk("t25_second_grant", 64'(grant_log[1]), 64'd0);
`endif

        // s0 continuously requesting alongside repeated s1 requests
        pulse_reset("rst2");
        grant_log.delete();
        fork
            for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 1'b0, 64'h400 + 64'(i), 64'd0, 2'd3, 0, 1'b0);
`ifdef MMIX_ARB_ROUND_ROBIN_EN
            for (int j = 0; j < 4; j++) do_txn(1, 1'b1, 1'b0, 64'h500 + 64'(j), 64'd0, 2'd3, 0, 1'b0);
`else
            for (int j = 0; j < 4; j++) do_txn(1, 1'b1, 1'b0, 64'h500 + 64'(j), 64'd0, 2'd3, 3, 1'b0);
`endif
        join
        chk("t27_grant_count", 64'(grant_log.size()), 64'd8);
`ifdef MMIX_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("t27_alternate", 64'(grant_log[i]), 64'(i % 2));
`endif

        // reset in the middle of a long downstream access
        ds_force_lat = 10;
        raise_req(0, 1'b1, 1'b0, 64'h600, 64'd0, 2'd3);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = mmix_read;
        end
        chk("t28_reached_busy", {63'd0, seen}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t28");
        clear_model();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        ds_force_lat = 0;
        @(posedge clk); #1;
        t0 = cyc;
        do_txn(1, 1'b1, 1'b0, 64'h700, 64'd0, 2'd0, 0, 1'b0);
        chk("t28_fresh_arb_edge", 64'(last_start_cyc), 64'(t0 + 1));
        chk("t28_fresh_grant", 64'(grant_log[$]), 64'd1);

        // randomized traffic on both ports with withdrawals and spurious pulses
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        repeat (5) @(posedge clk);
        #1;
        chk("drain_scoreboard", 64'(sbq.size()), 64'd0);
        chk("drain_pending", {62'd0, pend[1], pend[0]}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
